// File: rtl/dense_to_coo_fp8_encoder_pkg.sv
// Shared FP8 COO definitions: table geometry defaults, FSM states,
// and the E4M3 zero test used by both the encoder and the sparse matmul.
package fp8_coo_pkg;

  localparam int DEF_MAT_DIM = 8;
  localparam int DEF_IDX_W   = $clog2(DEF_MAT_DIM);
  localparam int DEF_MAX_NNZ = 32;

  typedef enum logic [1:0] {
    LOAD,
    SCAN,
    DONE
  } coo_state_e;

  // NaN encodings (0x7F/0xFF) fall out as nonzero naturally.
  function automatic logic is_fp8_zero(
    input logic [7:0] b,
    input logic       keep_neg_zero
  );
    return (b[6:0] == 7'd0) && (!b[7] || !keep_neg_zero);
  endfunction

endpackage

// File: rtl/dense_to_coo_fp8_encoder_picker.sv
// Lowest-set-bit priority encoder over a row nonzero mask.
// Also returns the mask with the picked bit removed.
module fp8_row_nz_picker #(
  parameter int W     = 8,
  parameter int IDX_W = 3
) (
  input  logic [W-1:0]     mask_i,
  output logic [IDX_W-1:0] col_o,
  output logic             any_o,
  output logic [W-1:0]     rest_o
);

  always_comb begin
    col_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (mask_i[i]) col_o = IDX_W'(i);
    end
    any_o  = |mask_i;
    rest_o = mask_i & (mask_i - W'(1));
  end

endmodule

// File: rtl/dense_to_coo_fp8_encoder.sv
// Streams a dense FP8 matrix in row by row and builds a frozen COO table
// (data/row/col/valid) handed to the sparse matmul via valid/ack.
module dense_to_coo_fp8_encoder
  import fp8_coo_pkg::*;
#(
  parameter int MAT_DIM       = DEF_MAT_DIM,
  parameter int MAX_NNZ       = DEF_MAX_NNZ,
  parameter bit KEEP_NEG_ZERO = 1'b0,
  localparam int IDX_W        = $clog2(MAT_DIM),
  localparam int CNT_W        = $clog2(MAX_NNZ) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MAT_DIM*8-1:0]     in_row_data,
  output logic                     out_valid,
  input  logic                     out_ack,
  output logic [MAX_NNZ*8-1:0]     coo_data,
  output logic [MAX_NNZ*IDX_W-1:0] coo_row,
  output logic [MAX_NNZ*IDX_W-1:0] coo_col,
  output logic [MAX_NNZ-1:0]       coo_valid,
  output logic [CNT_W-1:0]         nnz_count,
  output logic                     overflow
);

  localparam int WR_W = $clog2(MAX_NNZ);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(MAT_DIM - 1);

  coo_state_e                 state_q, state_d;
  logic [IDX_W-1:0]           row_cnt_q, row_cnt_d;
  logic [MAT_DIM*8-1:0]       row_buf_q, row_buf_d;
  logic [MAT_DIM-1:0]         mask_q, mask_d;
  logic [MAX_NNZ*8-1:0]       data_q, data_d;
  logic [MAX_NNZ*IDX_W-1:0]   row_q, row_d;
  logic [MAX_NNZ*IDX_W-1:0]   col_q, col_d;
  logic [MAX_NNZ-1:0]         vld_q, vld_d;
  logic [CNT_W-1:0]           nnz_q, nnz_d;
  logic                       ovf_q, ovf_d;

  logic [MAT_DIM-1:0]         in_mask;
  logic [IDX_W-1:0]           pick_col;
  logic                       pick_any;
  logic [MAT_DIM-1:0]         pick_rest;
  logic [WR_W-1:0]            wr_idx;

  always_comb begin
    in_mask = '0;
    for (int c = 0; c < MAT_DIM; c++) begin
      in_mask[c] = !is_fp8_zero(in_row_data[8*c +: 8], KEEP_NEG_ZERO);
    end
  end

  fp8_row_nz_picker #(
    .W     (MAT_DIM),
    .IDX_W (IDX_W)
  ) u_picker (
    .mask_i (mask_q),
    .col_o  (pick_col),
    .any_o  (pick_any),
    .rest_o (pick_rest)
  );

  assign wr_idx = nnz_q[WR_W-1:0];

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    row_buf_d = row_buf_q;
    mask_d    = mask_q;
    data_d    = data_q;
    row_d     = row_q;
    col_d     = col_q;
    vld_d     = vld_q;
    nnz_d     = nnz_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          row_buf_d = in_row_data;
          mask_d    = in_mask;
          if (|in_mask) begin
            state_d = SCAN;
          end else if (row_cnt_q == LAST_ROW) begin
            state_d = DONE;
          end else begin
            row_cnt_d = row_cnt_q + IDX_W'(1);
          end
        end
      end
      SCAN: begin
        if (pick_any) begin
          // A full table still burns the cycle so timing never depends on overflow.
          if (nnz_q == CNT_W'(MAX_NNZ)) begin
            ovf_d = 1'b1;
          end else begin
            data_d[8*wr_idx +: 8]         = row_buf_q[8*pick_col +: 8];
            row_d[IDX_W*wr_idx +: IDX_W]  = row_cnt_q;
            col_d[IDX_W*wr_idx +: IDX_W]  = pick_col;
            vld_d[wr_idx]                 = 1'b1;
            nnz_d                         = nnz_q + CNT_W'(1);
          end
        end
        mask_d = pick_rest;
        if (pick_rest == '0) begin
          if (row_cnt_q == LAST_ROW) begin
            state_d = DONE;
          end else begin
            row_cnt_d = row_cnt_q + IDX_W'(1);
            state_d   = LOAD;
          end
        end
      end
      DONE: begin
        if (out_ack) begin
          data_d    = '0;
          row_d     = '0;
          col_d     = '0;
          vld_d     = '0;
          nnz_d     = '0;
          ovf_d     = 1'b0;
          row_cnt_d = '0;
          mask_d    = '0;
          state_d   = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOAD;
      row_cnt_q <= '0;
      row_buf_q <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      vld_q     <= '0;
      nnz_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      row_buf_q <= row_buf_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      row_q     <= row_d;
      col_q     <= col_d;
      vld_q     <= vld_d;
      nnz_q     <= nnz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DONE);
  assign coo_data  = data_q;
  assign coo_row   = row_q;
  assign coo_col   = col_q;
  assign coo_valid = vld_q;
  assign nnz_count = nnz_q;
  assign overflow  = ovf_q;

endmodule
